serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial full subtractor: computes diff = a - b - bin over WIDTH bits, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a borrow flip-flop; it is the inverse-direction companion to the combinational full adder.
- Sits in the lab arithmetic library as the sequential datapath block.
- Host interface is a start/busy/done handshake with registered results.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; result registers valid.
- diff  output  WIDTH  registered difference.
- bout  output  1  registered borrow-out.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, and all internal shift, borrow and count registers = 0.
- States:
  - IDLE: busy=0, done=0. When start=1 at a rising edge: a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, go to SHIFT. When start=0, stay in IDLE.
  - SHIFT: busy=1. Each edge:
    - d = a_sh[0] ^ b_sh[0] ^ brw.
    - brw <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
    - a_sh and b_sh shift right by one; d shifts into the MSB of the partial-result register, which shifts right.
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1: load diff with the final partial result (including this d), load bout with the new brw, go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle. Next edge goes to IDLE unconditionally.
- Latency:
  - start sampled at edge k, so SHIFT covers edges k+1..k+WIDTH.
  - done is high in the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after start is accepted.
  - Back-to-back throughput is one op per WIDTH+2 cycles.
- Results:
  - diff = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff unsigned a < b + bin.
  - diff and bout change only on the edge entering DONE (or on reset) and hold through IDLE until the next completion. No partial values are visible.
- Boundary conditions:
  - start while busy (SHIFT or DONE) is ignored, with no queuing.
  - a, b and bin may change freely after capture without affecting the result.
  - start held high continuously: a new op is accepted on the first edge in IDLE after DONE.
  - Reset mid-operation: immediately forces the reset values. The aborted op produces no done and no result update.
  - No X-propagation: done must never pulse without a preceding accepted start.

Test Plan (WIDTH=8):
- a=0x5A, b=0x23, bin=0, start 1 cycle -> busy high for 9 cycles; done pulse exactly 9 cycles after the start edge; diff=0x37, bout=0.
- a=0x23, b=0x5A, bin=0 -> diff=0xC9, bout=1; diff/bout hold unchanged for 20 idle cycles afterwards.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- a=0xFF, b=0xFF, bin=0, then start pulsed again 3 cycles later with a=0x01, b=0x02 -> second start ignored; diff=0x00, bout=0; exactly one done pulse.
- Start a=0x80, b=0x01; assert rst asynchronously mid-cycle 4 cycles later -> busy=0, diff=0x00, bout=0 immediately, no done. After release, a=0x10, b=0x01 gives diff=0x0F, bout=0.
- start held high for 50 cycles with a=0x01, b=0x02, bin=0 -> done pulses every 10 cycles; every result diff=0xFF, bout=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, LSB first.
// A single full-subtractor cell feeds a borrow flip-flop. The host interface
// is start/busy/done, and the results are registered.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             brw_next;
  logic [WIDTH-1:0] part_next;

  // Full-subtractor cell acting on the current LSBs and the stored borrow.
  // The new difference bit enters the partial result from the top.
  always_comb begin
    d         = a_sh[0] ^ b_sh[0] ^ brw;
    brw_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
    part_next = {d, part[WIDTH-1:1]};
  end

  // Control FSM and datapath registers. The outputs are registered, and the
  // results update only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      part  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            part  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          part <= part_next;
          brw  <= brw_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= part_next;
            bout  <= brw_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
